// File: rtl/sysbus_arb_pkg.sv
// Shared types and constants for the two-master Sysbus arbiter.
package sysbus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   localparam logic [31:0] INVAL_TAG = 32'h0000_0800;

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts owned cycles until the owner's first request strobe,
// expiring at GRANT_TIMEOUT-1 and latching a sticky error.
module arb_watchdog #(
   parameter int unsigned GRANT_TIMEOUT = 256
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_start,
   input  logic i_active,
   input  logic i_reqcyc,
   output logic o_expire,
   output logic o_timeout_err
);

   localparam int unsigned CNT_W = (GRANT_TIMEOUT > 2) ? $clog2(GRANT_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GRANT_TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_seen;
   logic             r_err;

   assign o_expire      = i_active & ~r_seen & ~i_reqcyc & (r_cnt == CNT_MAX);
   assign o_timeout_err = r_err;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_seen <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         if (i_start) begin
            r_cnt  <= '0;
            r_seen <= 1'b0;
         end else if (i_active && !r_seen) begin
            // once the owner has issued a request the count freezes
            if (i_reqcyc) begin
               r_seen <= 1'b1;
            end else if (r_cnt != CNT_MAX) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
         if (o_expire) begin
            r_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter sharing one Sysbus port between icache and dcache, with
// owner-only response routing, invalidation snoop capture and grant watchdog.
module sysbus_arbiter
   import sysbus_arb_pkg::*;
#(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13,
   parameter int unsigned GRANT_TIMEOUT  = 256
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      icache_busreq,
   input  logic                      dcache_busreq,
   input  logic                      icache_busidle,
   input  logic                      dcache_busidle,
   output logic                      icache_busgrant,
   output logic                      dcache_busgrant,
   input  logic                      i_reqcyc,
   input  logic                      d_reqcyc,
   input  logic                      i_respack,
   input  logic                      d_respack,
   input  logic [BUS_DATA_WIDTH-1:0] i_req,
   input  logic [BUS_DATA_WIDTH-1:0] d_req,
   input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
   input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
   output logic                      i_respcyc,
   output logic                      d_respcyc,
   output logic                      i_reqack,
   output logic                      d_reqack,
   output logic                      bus_reqcyc,
   output logic                      bus_respack,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_respcyc,
   input  logic                      bus_reqack,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   output logic                      inval_valid,
   output logic [63:0]               inval_addr,
   output logic                      timeout_err
);

   arb_state_e r_state, w_state_d;
   owner_e     r_last_owner, w_owner_d;
   logic       r_inval_valid;
   logic [63:0] r_inval_addr;

   logic w_grant_i, w_grant_d, w_inval, w_resp_blk;
   logic w_start, w_active, w_expire;

   assign w_grant_i  = (r_state == GRANT_I);
   assign w_grant_d  = (r_state == GRANT_D);
   assign w_active   = w_grant_i | w_grant_d;
   assign w_inval    = bus_respcyc & (bus_resptag == BUS_TAG_WIDTH'(INVAL_TAG));
   // only a real response beat holds off release; snoop beats do not
   assign w_resp_blk = bus_respcyc & ~w_inval;

   assign icache_busgrant = w_grant_i;
   assign dcache_busgrant = w_grant_d;

   always_comb begin
      w_state_d = r_state;
      w_owner_d = r_last_owner;
      w_start   = 1'b0;
      unique case (r_state)
         // RELEASE is the dead turnaround cycle; pending requests are arbitrated
         // there so a regrant can follow it directly
         IDLE, RELEASE: begin
            w_state_d = IDLE;
            if (icache_busreq && (!dcache_busreq || r_last_owner == OWN_D)) begin
               w_state_d = GRANT_I;
               w_owner_d = OWN_I;
               w_start   = 1'b1;
            end else if (dcache_busreq) begin
               w_state_d = GRANT_D;
               w_owner_d = OWN_D;
               w_start   = 1'b1;
            end
         end
         GRANT_I: begin
            if (w_expire || (icache_busidle && !w_resp_blk)) begin
               w_state_d = RELEASE;
               if (w_expire) w_owner_d = OWN_I;
            end
         end
         GRANT_D: begin
            if (w_expire || (dcache_busidle && !w_resp_blk)) begin
               w_state_d = RELEASE;
               if (w_expire) w_owner_d = OWN_D;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_last_owner  <= OWN_D;
         r_inval_valid <= 1'b0;
         r_inval_addr  <= '0;
      end else begin
         r_state       <= w_state_d;
         r_last_owner  <= w_owner_d;
         r_inval_valid <= w_inval;
         if (w_inval) begin
            r_inval_addr <= 64'(bus_resp);
         end
      end
   end

   always_comb begin
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = w_inval;
      if (w_grant_i) begin
         bus_reqcyc  = i_reqcyc;
         bus_req     = i_req;
         bus_reqtag  = i_reqtag;
         bus_respack = i_respack;
      end else if (w_grant_d) begin
         bus_reqcyc  = d_reqcyc;
         bus_req     = d_req;
         bus_reqtag  = d_reqtag;
         bus_respack = d_respack;
      end
   end

   assign i_respcyc = bus_respcyc & w_grant_i & ~w_inval;
   assign d_respcyc = bus_respcyc & w_grant_d & ~w_inval;
   assign i_reqack  = bus_reqack & w_grant_i;
   assign d_reqack  = bus_reqack & w_grant_d;

   assign inval_valid = r_inval_valid;
   assign inval_addr  = r_inval_addr;

   arb_watchdog #(
      .GRANT_TIMEOUT (GRANT_TIMEOUT)
   ) u_watchdog (
      .i_clk         (clk),
      .i_rst         (reset),
      .i_start       (w_start),
      .i_active      (w_active),
      .i_reqcyc      (bus_reqcyc),
      .o_expire      (w_expire),
      .o_timeout_err (timeout_err)
   );

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: behavioural owner model compared every
// cycle, plus hand-computed expectations along the stimulus.
module tb_sysbus_arbiter;

   localparam int unsigned DW = 64;
   localparam int unsigned TW = 13;
   localparam int unsigned TO = 8;

   logic clk = 1'b0;
   logic reset;
   logic icache_busreq, dcache_busreq, icache_busidle, dcache_busidle;
   logic icache_busgrant, dcache_busgrant;
   logic i_reqcyc, d_reqcyc, i_respack, d_respack;
   logic [DW-1:0] i_req, d_req;
   logic [TW-1:0] i_reqtag, d_reqtag;
   logic i_respcyc, d_respcyc, i_reqack, d_reqack;
   logic bus_reqcyc, bus_respack;
   logic [DW-1:0] bus_req;
   logic [TW-1:0] bus_reqtag;
   logic bus_respcyc, bus_reqack;
   logic [DW-1:0] bus_resp;
   logic [TW-1:0] bus_resptag;
   logic inval_valid;
   logic [63:0] inval_addr;
   logic timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sysbus_arbiter #(
      .BUS_DATA_WIDTH (DW),
      .BUS_TAG_WIDTH  (TW),
      .GRANT_TIMEOUT  (TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .icache_busreq   (icache_busreq),
      .dcache_busreq   (dcache_busreq),
      .icache_busidle  (icache_busidle),
      .dcache_busidle  (dcache_busidle),
      .icache_busgrant (icache_busgrant),
      .dcache_busgrant (dcache_busgrant),
      .i_reqcyc        (i_reqcyc),
      .d_reqcyc        (d_reqcyc),
      .i_respack       (i_respack),
      .d_respack       (d_respack),
      .i_req           (i_req),
      .d_req           (d_req),
      .i_reqtag        (i_reqtag),
      .d_reqtag        (d_reqtag),
      .i_respcyc       (i_respcyc),
      .d_respcyc       (d_respcyc),
      .i_reqack        (i_reqack),
      .d_reqack        (d_reqack),
      .bus_reqcyc      (bus_reqcyc),
      .bus_respack     (bus_respack),
      .bus_req         (bus_req),
      .bus_reqtag      (bus_reqtag),
      .bus_respcyc     (bus_respcyc),
      .bus_reqack      (bus_reqack),
      .bus_resp        (bus_resp),
      .bus_resptag     (bus_resptag),
      .inval_valid     (inval_valid),
      .inval_addr      (inval_addr),
      .timeout_err     (timeout_err)
   );

   // Model: who owns the bus (0 none, 1 icache, 2 dcache), who owned it last,
   // how long the owner has gone without a request, plus snoop and error state.
   int          m_owner = 0;
   int          m_last  = 2;
   int          m_idle_cycles = 0;
   bit          m_seen  = 1'b0;
   bit          m_err   = 1'b0;
   bit          m_iv    = 1'b0;
   logic [63:0] m_ia    = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_owner = 0; m_last = 2; m_idle_cycles = 0; m_seen = 1'b0;
         m_err = 1'b0; m_iv = 1'b0; m_ia = '0;
      end else begin
         automatic bit inv = bus_respcyc && (bus_resptag == 13'h800);
         automatic bit reqc, idl, expired;
         m_iv = inv;
         if (inv) m_ia = bus_resp;
         if (m_owner != 0) begin
            reqc = (m_owner == 1) ? i_reqcyc : d_reqcyc;
            idl  = (m_owner == 1) ? icache_busidle : dcache_busidle;
            expired = !m_seen && !reqc && (m_idle_cycles == TO - 1);
            if (reqc) m_seen = 1'b1;
            else if (!m_seen) m_idle_cycles++;
            if (expired) begin
               m_err  = 1'b1;
               m_last = m_owner;
            end
            if (expired || (idl && !(bus_respcyc && !inv))) m_owner = 0;
         end else begin
            if (icache_busreq && dcache_busreq) m_owner = (m_last == 1) ? 2 : 1;
            else if (icache_busreq) m_owner = 1;
            else if (dcache_busreq) m_owner = 2;
            if (m_owner != 0) begin
               m_last = m_owner; m_idle_cycles = 0; m_seen = 1'b0;
            end
         end
      end
   end

   function automatic logic [150:0] model_out();
      logic gi, gd, inv, rq, ra;
      logic [DW-1:0] rd;
      logic [TW-1:0] rt;
      gi  = (m_owner == 1);
      gd  = (m_owner == 2);
      inv = bus_respcyc && (bus_resptag == 13'h800);
      rq  = gi ? i_reqcyc  : gd ? d_reqcyc  : 1'b0;
      rd  = gi ? i_req     : gd ? d_req     : '0;
      rt  = gi ? i_reqtag  : gd ? d_reqtag  : '0;
      ra  = gi ? i_respack : gd ? d_respack : inv;
      return {gi, gd, rq, ra, rd, rt, bus_respcyc & gi & ~inv, bus_respcyc & gd & ~inv,
              bus_reqack & gi, bus_reqack & gd, m_iv, m_ia, m_err};
   endfunction

   always @(negedge clk) begin
      automatic logic [150:0] exp_v = model_out();
      automatic logic [150:0] act_v = {icache_busgrant, dcache_busgrant, bus_reqcyc, bus_respack,
                                       bus_req, bus_reqtag, i_respcyc, d_respcyc, i_reqack,
                                       d_reqack, inval_valid, inval_addr, timeout_err};
      n_checks++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act_v, exp_v);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      icache_busreq = 0; dcache_busreq = 0; icache_busidle = 0; dcache_busidle = 0;
      i_reqcyc = 0; d_reqcyc = 0; i_respack = 0; d_respack = 0;
      i_req = '0; d_req = '0; i_reqtag = '0; d_reqtag = '0;
      bus_respcyc = 0; bus_reqack = 0; bus_resp = '0; bus_resptag = '0;
      tick(); tick();
      check("rst_grant_i", 64'(icache_busgrant), 64'd0);
      check("rst_grant_d", 64'(dcache_busgrant), 64'd0);
      check("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
      check("rst_timeout", 64'(timeout_err), 64'd0);
      check("rst_inval", 64'(inval_valid), 64'd0);
      reset = 1'b0;

      // single icache request
      icache_busreq = 1; i_reqcyc = 1; i_req = 64'h1111_2222_3333_4444; i_reqtag = 13'h005;
      d_req = 64'hdddd; d_reqtag = 13'h0aa;
      tick();
      check("t1_grant_i", 64'(icache_busgrant), 64'd1);
      check("t1_grant_d", 64'(dcache_busgrant), 64'd0);
      check("t1_reqcyc", 64'(bus_reqcyc), 64'd1);
      check("t1_req", bus_req, 64'h1111_2222_3333_4444);
      check("t1_reqtag", 64'(bus_reqtag), 64'h005);
      bus_reqack = 1;
      #1 check("t1_i_reqack", 64'({i_reqack, d_reqack}), 64'b10);
      bus_reqack = 0;
      icache_busreq = 0;
      tick();
      check("t1_withdraw_hold", 64'(icache_busgrant), 64'd1);
      icache_busidle = 1;
      tick();
      check("t1_release", 64'({icache_busgrant, dcache_busgrant}), 64'd0);
      check("t1_rel_reqcyc", 64'(bus_reqcyc), 64'd0);
      icache_busidle = 0;
      tick();

      // strict alternation from reset
      pulse_reset();
      icache_busreq = 1; dcache_busreq = 1; i_reqcyc = 1; d_reqcyc = 1;
      tick();
      for (int r = 0; r < 8; r++) begin
         check("alt_owner", 64'({icache_busgrant, dcache_busgrant}),
               (r % 2 == 0) ? 64'b10 : 64'b01);
         if (r % 2 == 0) icache_busidle = 1; else dcache_busidle = 1;
         tick();
         check("alt_turnaround", 64'({icache_busgrant, dcache_busgrant}), 64'd0);
         icache_busidle = 0; dcache_busidle = 0;
         tick();
      end
      icache_busreq = 0; dcache_busreq = 0; icache_busidle = 1;
      tick();
      icache_busidle = 0;

      // dcache owner receives a response; icache idle is ignored
      dcache_busreq = 1;
      tick();
      check("t3_grant_d", 64'(dcache_busgrant), 64'd1);
      dcache_busreq = 0;
      bus_respcyc = 1; bus_resptag = 13'h013; bus_resp = 64'h55; icache_busidle = 1;
      #1 check("t3_respcyc", 64'({i_respcyc, d_respcyc}), 64'b01);
      tick();
      check("t3_foreign_idle", 64'(dcache_busgrant), 64'd1);
      icache_busidle = 0; dcache_busidle = 1;
      tick();
      check("t3_idle_blocked", 64'(dcache_busgrant), 64'd1);
      bus_respcyc = 0;
      tick();
      check("t3_release", 64'(dcache_busgrant), 64'd0);
      dcache_busidle = 0;
      tick();

      // invalidation beat during icache ownership
      icache_busreq = 1;
      tick();
      check("t4_grant_i", 64'(icache_busgrant), 64'd1);
      icache_busreq = 0;
      bus_respcyc = 1; bus_resptag = 13'h800; bus_resp = 64'h8000_1040;
      #1 check("t4_no_fwd", 64'(i_respcyc), 64'd0);
      tick();
      check("t4_inval_valid", 64'(inval_valid), 64'd1);
      check("t4_inval_addr", inval_addr, 64'h8000_1040);
      bus_respcyc = 0;
      tick();
      check("t4_inval_pulse", 64'(inval_valid), 64'd0);
      check("t4_addr_held", inval_addr, 64'h8000_1040);
      icache_busidle = 1; bus_respcyc = 1; bus_resp = 64'h1234;
      tick();
      check("t4_inval_no_block", 64'(icache_busgrant), 64'd0);
      icache_busidle = 0;
      #1 check("t4_arb_respack", 64'(bus_respack), 64'd1);
      bus_respcyc = 0; bus_resptag = '0;
      tick();

      // watchdog
      pulse_reset();
      i_reqcyc = 0; d_reqcyc = 0; icache_busreq = 1; dcache_busreq = 1;
      tick();
      check("t5_grant_i", 64'(icache_busgrant), 64'd1);
      repeat (7) tick();
      check("t5_before_to", 64'({icache_busgrant, timeout_err}), 64'b10);
      tick();
      check("t5_timeout", 64'(timeout_err), 64'd1);
      check("t5_revoked", 64'({icache_busgrant, dcache_busgrant}), 64'd0);
      tick();
      check("t5_grant_d", 64'({icache_busgrant, dcache_busgrant}), 64'b01);
      check("t5_sticky", 64'(timeout_err), 64'd1);
      icache_busreq = 0; dcache_busreq = 0; d_reqcyc = 1; dcache_busidle = 1;
      tick();
      dcache_busidle = 0;
      tick();

      // asynchronous reset mid-grant
      pulse_reset();
      check("t6_err_cleared", 64'(timeout_err), 64'd0);
      icache_busreq = 1; i_reqcyc = 1;
      tick();
      check("t6_grant_i", 64'(icache_busgrant), 64'd1);
      #2 reset = 1'b1;
      #1 check("t6_async_grant", 64'({icache_busgrant, dcache_busgrant}), 64'd0);
      check("t6_async_reqcyc", 64'(bus_reqcyc), 64'd0);
      check("t6_async_req", bus_req, 64'd0);
      tick();
      reset = 1'b0; dcache_busreq = 1;
      tick();
      check("t6_tie_icache", 64'({icache_busgrant, dcache_busgrant}), 64'b10);
      icache_busreq = 0; dcache_busreq = 0;
      tick();

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
